// File: rtl/greater_run_if.sv
// Sample/record bus between the counter-comparator pair, the run tracker and its consumer.
interface greater_run_if #(
    parameter int LEN_W = 8
) ();
    logic             sample_en;
    logic             greater;
    logic [7:0]       value;
    logic             clr;
    logic             rec_ready;
    logic             rec_valid;
    logic [7:0]       rec_start;
    logic [LEN_W-1:0] rec_len;
    logic             busy;
    logic             drop;

    modport master (
        output sample_en, greater, value, clr, rec_ready,
        input  rec_valid, rec_start, rec_len, busy, drop
    );

    modport slave (
        input  sample_en, greater, value, clr, rec_ready,
        output rec_valid, rec_start, rec_len, busy, drop
    );
endinterface

// File: rtl/greater_run_tracker.sv
// Measures runs of consecutive greater=1 samples and queues {start, length}
// records in a small FIFO with a sticky drop flag for overflow.
module greater_run_tracker #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          Reset,
    greater_run_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       start_q, start_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             push;

    logic [7:0]       mem_start_q [DEPTH];
    logic [LEN_W-1:0] mem_len_q   [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             drop_q;
    logic             full, pop, push_ok, drop_set;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        push    = 1'b0;
        if (bus.sample_en) begin
            case (state_q)
                IDLE: if (bus.greater) begin
                    state_d = RUN;
                    start_d = bus.value;
                    len_d   = LEN_W'(1);
                end
                RUN: begin
                    if (bus.greater) begin
                        // Saturated runs keep going; only greater=0 ends a run.
                        if (len_q != '1) len_d = len_q + 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        pop      = (count_q != '0) && bus.rec_ready && !bus.clr;
        // When full, a simultaneous pop frees the slot the push lands in.
        push_ok  = push && !bus.clr && (!full || pop);
        drop_set = push && !bus.clr && full && !pop;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            start_q  <= '0;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_start_q[i] <= '0;
                mem_len_q[i]   <= '0;
            end
        end else if (bus.clr) begin
            state_q  <= IDLE;
            start_q  <= '0;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            if (push_ok) begin
                mem_start_q[wr_ptr_q] <= start_q;
                mem_len_q[wr_ptr_q]   <= len_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            drop_q <= drop_q | drop_set;
        end
    end

    assign bus.rec_valid = (count_q != '0);
    assign bus.rec_start = mem_start_q[rd_ptr_q];
    assign bus.rec_len   = mem_len_q[rd_ptr_q];
    assign bus.busy      = (state_q == RUN);
    assign bus.drop      = drop_q;
endmodule

// File: tb/tb_greater_run_tracker.sv
// Directed bench: main instance (DEPTH=4, LEN_W=8) plus a LEN_W=3 instance for saturation.
module tb_greater_run_tracker;
    logic clk;
    logic Reset;
    int   vecs;
    int   errs;

    greater_run_if #(.LEN_W(8)) bm ();
    greater_run_if #(.LEN_W(3)) bs ();

    greater_run_tracker #(.DEPTH(4), .LEN_W(8)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bm)
    );

    greater_run_tracker #(.DEPTH(4), .LEN_W(3)) dut_s (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic samp(input logic [7:0] v, input logic g);
        bm.sample_en = 1'b1;
        bm.value     = v;
        bm.greater   = g;
        tick();
        bm.sample_en = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] s, input logic [7:0] l);
        chk({tag, "_valid"}, 32'(bm.rec_valid), 32'd1);
        chk({tag, "_start"}, 32'(bm.rec_start), 32'(s));
        chk({tag, "_len"},   32'(bm.rec_len),   32'(l));
    endtask

    initial begin
        logic [7:0] v;
        logic       g;
        int         nrec;

        vecs = 0;
        errs = 0;
        Reset = 1'b0;
        bs.sample_en = 1'b0; bs.greater = 1'b0; bs.value = '0; bs.clr = 1'b0; bs.rec_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            bm.sample_en = 1'($urandom); bm.greater = 1'($urandom); bm.value = 8'($urandom);
            bm.clr = 1'($urandom); bm.rec_ready = 1'($urandom);
            tick();
        end
        chk("rst_valid", 32'(bm.rec_valid), 32'd0);
        chk("rst_busy",  32'(bm.busy),      32'd0);
        chk("rst_drop",  32'(bm.drop),      32'd0);
        chk("rst_start", 32'(bm.rec_start), 32'd0);
        chk("rst_len",   32'(bm.rec_len),   32'd0);
        bm.sample_en = 1'b0; bm.greater = 1'b0; bm.value = '0; bm.clr = 1'b0; bm.rec_ready = 1'b0;
        Reset = 1'b1;
        tick();

        // Short sweep 0x00..0x3F with consumer always ready
        bm.rec_ready = 1'b1;
        nrec = 0;
        for (int i = 0; i < 64; i++) begin
            v = 8'(i);
            g = (v[7:4] > v[3:0]);
            samp(v, g);
            chk("sweep_busy", 32'(bm.busy), 32'(g));
            if (bm.rec_valid) nrec++;
            if (v == 8'h11) chk_head("sweep_r1", 8'h10, 8'd1);
            if (v == 8'h22) chk_head("sweep_r2", 8'h20, 8'd2);
            if (v == 8'h33) chk_head("sweep_r3", 8'h30, 8'd3);
        end
        chk("sweep_nrec", 32'(nrec), 32'd3);

        // Fill and overflow with consumer stalled
        bm.rec_ready = 1'b0;
        for (int i = 0; i < 96; i++) begin
            v = 8'(i);
            samp(v, (v[7:4] > v[3:0]));
            if (v == 8'h54) chk("full_nodrop", 32'(bm.drop), 32'd0);
            if (v == 8'h55) chk("full_drop",   32'(bm.drop), 32'd1);
        end
        bm.rec_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk_head("drain", 8'(16 * i), 8'(i));
            tick();
        end
        chk("drain_empty",  32'(bm.rec_valid), 32'd0);
        chk("drain_drop",   32'(bm.drop),      32'd1);

        // clr mid-run with 2 records queued; also clears drop
        bm.rec_ready = 1'b0;
        samp(8'h61, 1'b1); samp(8'h62, 1'b0);
        samp(8'h63, 1'b1); samp(8'h64, 1'b0);
        samp(8'h65, 1'b1);
        chk("clr_pre_busy", 32'(bm.busy), 32'd1);
        bm.clr = 1'b1; bm.rec_ready = 1'b1;
        samp(8'h66, 1'b1);
        bm.clr = 1'b0; bm.rec_ready = 1'b0;
        chk("clr_busy",  32'(bm.busy),      32'd0);
        chk("clr_valid", 32'(bm.rec_valid), 32'd0);
        chk("clr_drop",  32'(bm.drop),      32'd0);
        samp(8'h42, 1'b1); samp(8'h43, 1'b0);
        chk_head("clr_fresh", 8'h42, 8'd1);

        // Full FIFO, push and pop on the same edge
        bm.clr = 1'b1; tick(); bm.clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            samp(8'hA0 + 8'(i), 1'b1);
            samp(8'h00, 1'b0);
        end
        samp(8'hE5, 1'b1);
        samp(8'hE6, 1'b1);
        bm.rec_ready = 1'b1;
        samp(8'h00, 1'b0);
        chk("pp_drop", 32'(bm.drop), 32'd0);
        chk_head("pp_h1", 8'hA1, 8'd1); tick();
        chk_head("pp_h2", 8'hA2, 8'd1); tick();
        chk_head("pp_h3", 8'hA3, 8'd1); tick();
        chk_head("pp_h4", 8'hE5, 8'd2); tick();
        chk("pp_empty", 32'(bm.rec_valid), 32'd0);

        // Saturation on the LEN_W=3 instance
        for (int i = 0; i < 10; i++) begin
            bs.sample_en = 1'b1; bs.greater = 1'b1; bs.value = 8'h77 + 8'(i);
            tick();
        end
        chk("sat_busy", 32'(bs.busy), 32'd1);
        bs.greater = 1'b0; bs.value = 8'h01;
        tick();
        bs.sample_en = 1'b0;
        chk("sat_valid", 32'(bs.rec_valid), 32'd1);
        chk("sat_start", 32'(bs.rec_start), 32'h77);
        chk("sat_len",   32'(bs.rec_len),   32'd7);

        // Asynchronous reset mid-run with a record queued
        bm.rec_ready = 1'b0;
        samp(8'h90, 1'b1); samp(8'h91, 1'b0);
        samp(8'h95, 1'b1);
        chk("arst_pre_busy", 32'(bm.busy), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bm.rec_valid), 32'd0);
        chk("arst_busy",  32'(bm.busy),      32'd0);
        chk("arst_start", 32'(bm.rec_start), 32'd0);
        chk("arst_len",   32'(bm.rec_len),   32'd0);
        chk("arst_sval",  32'(bs.rec_valid), 32'd0);
        #2 Reset = 1'b1;
        samp(8'hC2, 1'b1); samp(8'hC3, 1'b0);
        chk_head("arst_fresh", 8'hC2, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
